ip_mod_conv: RTL and testbench



---
 rtl/ip_mod_conv_pkg.sv | 51 +++++
 rtl/ip_mod_conv_core.sv | 155 +++++++++++++++
 rtl/ip_mod_conv.sv | 179 +++++++++++++++++
 tb/tb_ip_mod_conv.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ip_mod_conv_pkg.sv
// ---------------------------------------------------------------------------
// ip_mod_conv_pkg
// Shared definitions for the AIP-wrapped 1-D convolution accelerator:
// default sizes, AIP config codes, STATUS/CONF field positions, FSM state
// type and the CONF length decode helper.
// ---------------------------------------------------------------------------
package ip_mod_conv_pkg;

  localparam int DATAWIDTH_DEF = 32;
  localparam int SIZE_X_DEF    = 32;
  localparam int SIZE_Y_DEF    = 32;
  localparam int SIZE_Z_DEF    = 64;
  localparam logic [31:0] IP_ID_DEF = 32'h1000500C;

  // AIP config codes
  localparam logic [4:0] CFG_X_MEM    = 5'd0;
  localparam logic [4:0] CFG_X_PTR    = 5'd1;
  localparam logic [4:0] CFG_Y_MEM    = 5'd2;
  localparam logic [4:0] CFG_Y_PTR    = 5'd3;
  localparam logic [4:0] CFG_Z_MEM    = 5'd4;
  localparam logic [4:0] CFG_Z_PTR    = 5'd5;
  localparam logic [4:0] CFG_CONF_MEM = 5'd6;
  localparam logic [4:0] CFG_CONF_PTR = 5'd7;
  localparam logic [4:0] CFG_STATUS   = 5'd30;
  localparam logic [4:0] CFG_IP_ID    = 5'd31;

  // STATUS register layout
  localparam int STAT_DONE     = 0;
  localparam int STAT_BUSY     = 8;
  localparam int STAT_MASK_LSB = 16;
  localparam int STAT_MASK_MSB = 23;

  // CONF register layout
  localparam int CONF_W       = 11;
  localparam int CONF_FIELD_W = 5;
  localparam int CONF_NX_LSB  = 0;
  localparam int CONF_NY_LSB  = 5;
  localparam int CONF_SHAPE   = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } conv_state_t;

  // A length field of zero means the full depth (2**CONF_FIELD_W).
  function automatic logic [CONF_FIELD_W:0] decode_len(input logic [CONF_FIELD_W-1:0] f);
    return (f == '0) ? {1'b1, {CONF_FIELD_W{1'b0}}} : {1'b0, f};
  endfunction

endpackage

// File: rtl/ip_mod_conv_core.sv
// ---------------------------------------------------------------------------
// conv_core
// Convolution engine: IDLE -> CALC -> DONE FSM, output/tap index counters
// and a 32-bit wrapping signed MAC.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                synchronous enable (0 freezes every register)
//   start             start pulse, honoured only in IDLE
//   nx, ny, shape     decoded vector lengths (1..SIZE) and output shape
//   x_addr/x_data     X RAM read port (data arrives one cycle after address)
//   y_addr/y_data     Y RAM read port (data arrives one cycle after address)
//   z_we/z_addr/z_data Z RAM write port
//   busy              FSM not in IDLE
//   done_set          high for the single DONE cycle
// Each output n spends SIZE_X tap cycles issuing addresses plus one cycle in
// which the last tap's data lands and z[n] is written, so the RAM read
// latency is absorbed without extra cycles.
// ---------------------------------------------------------------------------
module conv_core
  import ip_mod_conv_pkg::*;
#(
  parameter int DW     = 32,
  parameter int SIZE_X = 32,
  parameter int SIZE_Y = 32,
  parameter int SIZE_Z = 64,
  parameter int XAW    = $clog2(SIZE_X),
  parameter int YAW    = $clog2(SIZE_Y),
  parameter int ZAW    = $clog2(SIZE_Z)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           start,
  input  logic [XAW:0]   nx,
  input  logic [YAW:0]   ny,
  input  logic           shape,
  output logic [XAW-1:0] x_addr,
  input  logic [DW-1:0]  x_data,
  output logic [YAW-1:0] y_addr,
  input  logic [DW-1:0]  y_data,
  output logic           z_we,
  output logic [ZAW-1:0] z_addr,
  output logic [DW-1:0]  z_data,
  output logic           busy,
  output logic           done_set
);

  // Index arithmetic width: holds n + NY/2 and the difference n' - k.
  localparam int IW = ZAW + 2;
  localparam logic [XAW:0] K_LAST = (XAW + 1)'(SIZE_X);

  conv_state_t state_reg, state_next;

  logic [ZAW-1:0] n_reg;
  logic [XAW:0]   k_reg;
  logic [DW-1:0]  acc_reg;
  logic           term_valid_reg;   // qualifies the RAM data arriving now

  logic           last_phase;
  logic           term_valid;
  logic           out_valid;
  logic [IW-1:0]  n_ext, k_ext, nx_ext, ny_ext, m_val, diff;
  logic signed [DW-1:0] prod;
  logic [DW-1:0]  term;

  // Index / address / MAC datapath
  always_comb begin
    n_ext  = IW'(n_reg);
    k_ext  = IW'(k_reg);
    nx_ext = IW'(nx);
    ny_ext = IW'(ny);
    // "same" shape reads the full result shifted by floor(NY/2)
    m_val  = shape ? n_ext : (n_ext + (ny_ext >> 1));
    diff   = m_val - k_ext;
    last_phase = (k_reg == K_LAST);
    term_valid = (state_reg == ST_CALC) && !last_phase &&
                 (k_ext < nx_ext) && (m_val >= k_ext) && (diff < ny_ext);
    out_valid  = shape ? ((n_ext + IW'(1)) < (nx_ext + ny_ext)) : (n_ext < nx_ext);
    x_addr = k_reg[XAW-1:0];
    y_addr = diff[YAW-1:0];
    z_addr = n_reg;
    // Low DW bits of the product are the wrapped signed result.
    prod   = $signed(x_data) * $signed(y_data);
    term   = term_valid_reg ? prod : '0;
    z_data = out_valid ? (acc_reg + term) : '0;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else if (en) begin
      state_reg <= state_next;
    end
  end

  // FSM next state and control outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done_set   = 1'b0;
    z_we       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (last_phase) begin
          z_we = 1'b1;
          if (n_reg == ZAW'(SIZE_Z - 1)) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done_set   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Counters and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg          <= '0;
      k_reg          <= '0;
      acc_reg        <= '0;
      term_valid_reg <= 1'b0;
    end else if (en) begin
      term_valid_reg <= term_valid;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            n_reg   <= '0;
            k_reg   <= '0;
            acc_reg <= '0;
          end
        end
        ST_CALC: begin
          if (!last_phase) begin
            acc_reg <= acc_reg + term;
            k_reg   <= k_reg + (XAW + 1)'(1);
          end else begin
            acc_reg <= '0;
            k_reg   <= '0;
            n_reg   <= n_reg + ZAW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ip_mod_conv.sv
// ---------------------------------------------------------------------------
// ip_mod_conv
// AIP-bus wrapper around conv_core: config-code decode, auto-increment
// pointers, X/Y/Z memories, CONF register, STATUS and interrupt.
// Ports:
//   clk        system clock
//   rst_a      asynchronous active-low reset
//   en_s       synchronous enable, 0 holds every register and memory
//   data_in    host write data
//   data_out   host read data, registered on the read strobe edge
//   write/read host strobes, one word per high cycle
//   start      start pulse
//   conf_dbus  config code selecting the access target
//   int_req    active-low interrupt = ~|(flags & mask)
// ---------------------------------------------------------------------------
module ip_mod_conv
  import ip_mod_conv_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int SIZE_X    = SIZE_X_DEF,
  parameter int SIZE_Y    = SIZE_Y_DEF,
  parameter int SIZE_Z    = SIZE_Z_DEF,
  parameter logic [31:0] IP_ID_VAL = IP_ID_DEF
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 en_s,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic [DATAWIDTH-1:0] data_out,
  input  logic                 write,
  input  logic                 read,
  input  logic                 start,
  input  logic [4:0]           conf_dbus,
  output logic                 int_req
);

  localparam int XAW = $clog2(SIZE_X);
  localparam int YAW = $clog2(SIZE_Y);
  localparam int ZAW = $clog2(SIZE_Z);

  logic [DATAWIDTH-1:0] mem_x [SIZE_X];
  logic [DATAWIDTH-1:0] mem_y [SIZE_Y];
  logic [DATAWIDTH-1:0] mem_z [SIZE_Z];

  logic [XAW-1:0]    ptr_x_reg;
  logic [YAW-1:0]    ptr_y_reg;
  logic [ZAW-1:0]    ptr_z_reg;
  logic [CONF_W-1:0] conf_reg;
  logic              done_reg;
  logic [7:0]        mask_reg;

  logic [DATAWIDTH-1:0] x_rd_reg, y_rd_reg;
  logic [DATAWIDTH-1:0] status_word;

  logic [XAW-1:0]       core_x_addr;
  logic [YAW-1:0]       core_y_addr;
  logic                 core_z_we;
  logic [ZAW-1:0]       core_z_addr;
  logic [DATAWIDTH-1:0] core_z_data;
  logic                 core_busy;
  logic                 core_done_set;

  // Host strobes decoded by config code
  logic wr_x, wr_y, wr_conf, wr_status;
  logic rd_x, rd_y, rd_z;
  always_comb begin
    wr_x      = write && (conf_dbus == CFG_X_MEM);
    wr_y      = write && (conf_dbus == CFG_Y_MEM);
    wr_conf   = write && (conf_dbus == CFG_CONF_MEM);
    wr_status = write && (conf_dbus == CFG_STATUS);
    rd_x      = read  && (conf_dbus == CFG_X_MEM);
    rd_y      = read  && (conf_dbus == CFG_Y_MEM);
    rd_z      = read  && (conf_dbus == CFG_Z_MEM);
  end

  // Memories: host write into X/Y, core write into Z, registered reads.
  always_ff @(posedge clk) begin
    if (en_s) begin
      if (wr_x) mem_x[ptr_x_reg] <= data_in;
      x_rd_reg <= mem_x[core_x_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (en_s) begin
      if (wr_y) mem_y[ptr_y_reg] <= data_in;
      y_rd_reg <= mem_y[core_y_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (en_s && core_z_we) mem_z[core_z_addr] <= core_z_data;
  end

  // Pointers: explicit load wins over post-increment; widths wrap modulo depth.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      ptr_x_reg <= '0;
      ptr_y_reg <= '0;
      ptr_z_reg <= '0;
    end else if (en_s) begin
      if (write && conf_dbus == CFG_X_PTR) ptr_x_reg <= data_in[XAW-1:0];
      else if (wr_x || rd_x)               ptr_x_reg <= ptr_x_reg + XAW'(1);

      if (write && conf_dbus == CFG_Y_PTR) ptr_y_reg <= data_in[YAW-1:0];
      else if (wr_y || rd_y)               ptr_y_reg <= ptr_y_reg + YAW'(1);

      if (write && conf_dbus == CFG_Z_PTR) ptr_z_reg <= data_in[ZAW-1:0];
      else if (rd_z)                       ptr_z_reg <= ptr_z_reg + ZAW'(1);
    end
  end

  // CONF and STATUS; a done event in the same cycle as a clear keeps done set.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      conf_reg <= '0;
      done_reg <= 1'b0;
      mask_reg <= '0;
    end else if (en_s) begin
      if (wr_conf)   conf_reg <= data_in[CONF_W-1:0];
      if (wr_status) mask_reg <= data_in[STAT_MASK_MSB:STAT_MASK_LSB];
      done_reg <= core_done_set | (done_reg & ~(wr_status & data_in[STAT_DONE]));
    end
  end

  always_comb begin
    status_word                              = '0;
    status_word[STAT_DONE]                   = done_reg;
    status_word[STAT_BUSY]                   = core_busy;
    status_word[STAT_MASK_MSB:STAT_MASK_LSB] = mask_reg;
  end

  assign int_req = ~|({7'b0, done_reg} & mask_reg);

  // Host read data register
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      data_out <= '0;
    end else if (en_s && read) begin
      case (conf_dbus)
        CFG_X_MEM:    data_out <= mem_x[ptr_x_reg];
        CFG_X_PTR:    data_out <= DATAWIDTH'(ptr_x_reg);
        CFG_Y_MEM:    data_out <= mem_y[ptr_y_reg];
        CFG_Y_PTR:    data_out <= DATAWIDTH'(ptr_y_reg);
        CFG_Z_MEM:    data_out <= mem_z[ptr_z_reg];
        CFG_Z_PTR:    data_out <= DATAWIDTH'(ptr_z_reg);
        CFG_CONF_MEM: data_out <= DATAWIDTH'(conf_reg);
        CFG_STATUS:   data_out <= status_word;
        CFG_IP_ID:    data_out <= DATAWIDTH'(IP_ID_VAL);
        default:      data_out <= '0;   // includes the always-zero CONF pointer
      endcase
    end
  end

  conv_core #(
    .DW     (DATAWIDTH),
    .SIZE_X (SIZE_X),
    .SIZE_Y (SIZE_Y),
    .SIZE_Z (SIZE_Z)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_a),
    .en       (en_s),
    .start    (start),
    .nx       (decode_len(conf_reg[CONF_NX_LSB +: CONF_FIELD_W])),
    .ny       (decode_len(conf_reg[CONF_NY_LSB +: CONF_FIELD_W])),
    .shape    (conf_reg[CONF_SHAPE]),
    .x_addr   (core_x_addr),
    .x_data   (x_rd_reg),
    .y_addr   (core_y_addr),
    .y_data   (y_rd_reg),
    .z_we     (core_z_we),
    .z_addr   (core_z_addr),
    .z_data   (core_z_data),
    .busy     (core_busy),
    .done_set (core_done_set)
  );

endmodule

// File: tb/tb_ip_mod_conv.sv
// ---------------------------------------------------------------------------
// tb_ip_mod_conv
// Scoreboard bench: expected Z words are queued when a convolution is
// started and popped as Z is read back over the AIP bus.
// ---------------------------------------------------------------------------
module tb_ip_mod_conv;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        en_s = 1'b1;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  conf_dbus = '0;
  logic        int_req;

  always #5 clk = ~clk;

  ip_mod_conv dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .en_s      (en_s),
    .data_in   (data_in),
    .data_out  (data_out),
    .write     (write),
    .read      (read),
    .start     (start),
    .conf_dbus (conf_dbus),
    .int_req   (int_req)
  );

  int pass_cnt  = 0;
  int check_cnt = 0;
  int exp_q[$];
  int x_m[32];
  int y_m[32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [4:0] code, input logic [31:0] d);
    @(negedge clk);
    conf_dbus = code;
    data_in   = d;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
    $display("wr code=%0d data=0x%08h", code, d);
  endtask

  task automatic bus_read(input logic [4:0] code, output logic [31:0] d);
    @(negedge clk);
    conf_dbus = code;
    read      = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d    = data_out;
    $display("rd code=%0d data=0x%08h", code, d);
  endtask

  task automatic load_x(input int count);
    bus_write(5'd1, 32'd0);
    for (int i = 0; i < count; i++) bus_write(5'd0, x_m[i]);
  endtask

  task automatic load_y(input int count);
    bus_write(5'd3, 32'd0);
    for (int i = 0; i < count; i++) bus_write(5'd2, y_m[i]);
  endtask

  // Reference: direct sum over the full convolution, then shape selection.
  function automatic int model_z(input int nx, input int ny, input bit shape, input int n);
    int m;
    int acc;
    if (shape) begin
      if (n >= nx + ny - 1) return 0;
      m = n;
    end else begin
      if (n >= nx) return 0;
      m = n + ny / 2;
    end
    acc = 0;
    for (int k = 0; k < nx; k++)
      if ((m - k) >= 0 && (m - k) < ny) acc += x_m[k] * y_m[m - k];
    return acc;
  endfunction

  task automatic push_model(input int nx, input int ny, input bit shape);
    for (int n = 0; n < 64; n++) exp_q.push_back(model_z(nx, ny, shape, n));
  endtask

  // Run one convolution and drain the scoreboard. A second start is pulsed
  // while busy, and en_s is dropped for en_gap cycles; both show up in latency.
  task automatic run_conv(input logic [31:0] conf, input int en_gap, input string tag);
    logic [31:0] d;
    int cnt;
    bus_write(5'd30, 32'h0001_0001);
    bus_write(5'd6, conf);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus_read(5'd30, d);
    check_eq($sformatf("%s_busy", tag), d, 32'h0001_0100);
    cnt = 2;
    while (int_req !== 1'b0 && cnt < 6000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 100) start = 1'b1;
      if (cnt == 101) start = 1'b0;
      if (en_gap > 0 && cnt == 200) en_s = 1'b0;
      if (cnt == 200 + en_gap) en_s = 1'b1;
    end
    en_s = 1'b1;
    check_eq($sformatf("%s_latency", tag), cnt, 2113 + en_gap);
    bus_read(5'd30, d);
    check_eq($sformatf("%s_status_done", tag), d, 32'h0001_0001);
    bus_write(5'd5, 32'd0);
    for (int n = 0; n < 64; n++) begin
      bus_read(5'd4, d);
      if (exp_q.size() == 0) check_eq($sformatf("%s_z%0d_noexp", tag, n), d, 32'hxxxx_xxxx);
      else check_eq($sformatf("%s_z%0d", tag, n), d, exp_q.pop_front());
    end
    bus_read(5'd5, d);
    check_eq($sformatf("%s_zptr_wrap", tag), d, 32'd0);
    bus_write(5'd30, 32'h0001_0001);
    check_eq($sformatf("%s_irq_cleared", tag), {31'd0, int_req}, 32'd1);
    bus_read(5'd30, d);
    check_eq($sformatf("%s_status_clr", tag), d, 32'h0001_0000);
  endtask

  initial begin : main
    logic [31:0] d;
    int full_tab[14];
    int nx, ny;
    bit shape;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_data_out", data_out, 32'd0);
    check_eq("rst_int_req", {31'd0, int_req}, 32'd1);
    rst_a = 1'b1;
    bus_read(5'd31, d);
    check_eq("ip_id", d, 32'h1000_500C);
    bus_read(5'd30, d);
    check_eq("status_rst", d, 32'h0000_0000);
    bus_write(5'd30, 32'h0001_0000);
    bus_read(5'd30, d);
    check_eq("status_mask", d, 32'h0001_0000);
    check_eq("irq_masked_idle", {31'd0, int_req}, 32'd1);

    // A: X = 1..32, Y = ones, full, NX = NY = 32 (field value 0)
    for (int i = 0; i < 32; i++) begin
      x_m[i] = i + 1;
      y_m[i] = 1;
    end
    load_x(32);
    bus_read(5'd1, d);
    check_eq("xptr_wrap", d, 32'd0);
    load_y(32);
    bus_write(5'd1, 32'd3);
    bus_read(5'd0, d);
    check_eq("x_readback3", d, 32'd4);
    bus_read(5'd1, d);
    check_eq("xptr_postinc", d, 32'd4);
    for (int n = 0; n < 64; n++)
      exp_q.push_back(n < 32 ? (n + 1) * (n + 2) / 2 : 528 - (n - 31) * (n - 30) / 2);
    run_conv(32'h0000_0400, 0, "ramp_full");

    // B: X = 1..5, Y = 10 ones, full
    for (int i = 0; i < 5; i++) x_m[i] = i + 1;
    load_x(5);
    bus_read(5'd1, d);
    check_eq("xptr_after5", d, 32'd5);
    load_y(10);
    full_tab = '{1, 3, 6, 10, 15, 15, 15, 15, 15, 15, 14, 12, 9, 5};
    for (int n = 0; n < 64; n++) exp_q.push_back(n < 14 ? full_tab[n] : 0);
    run_conv(32'h0000_0545, 0, "short_full");

    // C: same data, "same" shape, with a 50-cycle enable gap
    push_model(5, 10, 1'b0);
    run_conv(32'h0000_0145, 50, "short_same");

    // D: random signed data and lengths
    nx    = $urandom_range(1, 32);
    ny    = $urandom_range(1, 32);
    shape = 1'($urandom_range(0, 1));
    for (int i = 0; i < 32; i++) begin
      x_m[i] = $urandom;
      y_m[i] = $urandom;
    end
    load_x(32);
    load_y(32);
    push_model(nx, ny, shape);
    run_conv({21'd0, shape, 5'(ny % 32), 5'(nx % 32)}, 0, "random");

    // Reset in the middle of a calculation
    bus_write(5'd6, 32'h0000_0400);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check_eq("midrst_int_req", {31'd0, int_req}, 32'd1);
    rst_a = 1'b1;
    bus_read(5'd30, d);
    check_eq("midrst_status", d, 32'h0000_0000);
    bus_write(5'd30, 32'h0001_0000);
    repeat (2200) @(negedge clk);
    check_eq("midrst_no_done_irq", {31'd0, int_req}, 32'd1);
    bus_read(5'd30, d);
    check_eq("midrst_status_idle", d, 32'h0001_0000);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
